// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: load-use bubbles, branch kill and memory-busy freeze for a 5-stage RV32 pipeline
module pipeline_hazard_controller #(
  parameter int LOAD_LATENCY = 1,
  parameter int MAX_WAIT = 255,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RdE,
  input  logic             MemReadE,
  input  logic             BranchTakenE,
  input  logic             MemBusyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       hazard_state,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);
  typedef enum logic [1:0] {RUN = 2'b00, LOAD_STALL = 2'b01, MEM_WAIT = 2'b10} state_t;
  state_t state_q, state_d;
  logic [2:0] bub_cnt_q, bub_cnt_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic lu, in_ls;
  always_comb begin
    lu = MemReadE && RdE != 5'd0 && (RdE == Rs1D || RdE == Rs2D);
    in_ls = state_q == LOAD_STALL;
    StallM = reset && MemBusyM;
    StallE = StallM;
    StallF = reset && (MemBusyM || in_ls || (!BranchTakenE && lu));
    StallD = StallF;
    FlushD = reset && !MemBusyM && !in_ls && BranchTakenE;
    FlushE = reset && !MemBusyM && (in_ls || BranchTakenE || lu);
    wait_cnt_d = !MemBusyM ? 8'd0 : (wait_cnt_q == 8'hff ? wait_cnt_q : wait_cnt_q + 8'd1);
    bub_cnt_d = bub_cnt_q;
    state_d = RUN;
    if (MemBusyM) state_d = in_ls ? LOAD_STALL : MEM_WAIT;
    else if (in_ls) begin
      bub_cnt_d = bub_cnt_q - 3'd1;
      state_d = bub_cnt_q == 3'd1 ? RUN : LOAD_STALL;
    end else if (!BranchTakenE && lu && LOAD_LATENCY > 1) begin
      bub_cnt_d = 3'(LOAD_LATENCY - 1);
      state_d = LOAD_STALL;
    end
    // timeout fires on the edge at which the busy run reaches MAX_WAIT cycles
    mem_timeout_d = mem_timeout_q || (MemBusyM && wait_cnt_d == 8'(MAX_WAIT));
    stall_cycles_d = (StallF && stall_cycles_q != '1) ? stall_cycles_q + CNT_W'(1) : stall_cycles_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= RUN;
      bub_cnt_q <= 3'd0;
      wait_cnt_q <= 8'd0;
      mem_timeout_q <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      state_q <= state_d;
      bub_cnt_q <= bub_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end
  assign hazard_state = state_q;
  assign mem_timeout = mem_timeout_q;
  assign stall_cycles = stall_cycles_q;
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb_pipeline_hazard_controller: two parameterisations driven together, scoreboarded against a bubble-debt model
module tb_pipeline_hazard_controller;
  logic clk = 1'b0;
  logic reset, MemReadE, BranchTakenE, MemBusyM;
  logic [4:0] Rs1D, Rs2D, RdE;
  logic sf_a, sd_a, se_a, sm_a, fd_a, fe_a, to_a;
  logic sf_b, sd_b, se_b, sm_b, fd_b, fe_b, to_b;
  logic [1:0] hs_a, hs_b;
  logic [31:0] sc_a;
  logic [3:0] sc_b;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;

  pipeline_hazard_controller #(.LOAD_LATENCY(1), .MAX_WAIT(255), .CNT_W(32)) dut_a (
    .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdE(RdE), .MemReadE(MemReadE),
    .BranchTakenE(BranchTakenE), .MemBusyM(MemBusyM), .StallF(sf_a), .StallD(sd_a),
    .StallE(se_a), .StallM(sm_a), .FlushD(fd_a), .FlushE(fe_a), .hazard_state(hs_a),
    .mem_timeout(to_a), .stall_cycles(sc_a));
  pipeline_hazard_controller #(.LOAD_LATENCY(3), .MAX_WAIT(3), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdE(RdE), .MemReadE(MemReadE),
    .BranchTakenE(BranchTakenE), .MemBusyM(MemBusyM), .StallF(sf_b), .StallD(sd_b),
    .StallE(se_b), .StallM(sm_b), .FlushD(fd_b), .FlushE(fe_b), .hazard_state(hs_b),
    .mem_timeout(to_b), .stall_cycles(sc_b));

  typedef struct packed {
    logic [5:0]  ctl;
    logic [1:0]  hs;
    logic        to;
    logic [31:0] sc;
    logic        regs;
  } exp_t;
  exp_t qa[$], qb[$];

  int ll[2] = '{1, 3};
  int mw[2] = '{255, 3};
  logic [31:0] scmax[2] = '{32'hffff_ffff, 32'd15};
  int rem[2], busy[2];
  bit to_m[2], known[2];
  logic [31:0] sc_m[2];

  function automatic exp_t predict(int k);
    exp_t e;
    bit lu;
    lu = MemReadE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
    e.ctl = !reset ? 6'b000000 : MemBusyM ? 6'b111100 : rem[k] > 0 ? 6'b110001 :
            BranchTakenE ? 6'b000011 : lu ? 6'b110001 : 6'b000000;
    e.hs = rem[k] > 0 ? 2'b01 : busy[k] > 0 ? 2'b10 : 2'b00;
    e.to = to_m[k];
    e.sc = sc_m[k];
    e.regs = known[k];
    return e;
  endfunction

  task automatic advance(int k, logic stall_f);
    bit lu;
    lu = MemReadE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
    if (!reset) begin
      rem[k] = 0; busy[k] = 0; to_m[k] = 0; sc_m[k] = 0; known[k] = 1;
    end else begin
      if (stall_f && sc_m[k] != scmax[k]) sc_m[k] = sc_m[k] + 1;
      if (MemBusyM) begin
        busy[k]++;
        if (busy[k] >= mw[k]) to_m[k] = 1;
      end else begin
        busy[k] = 0;
        if (rem[k] > 0) rem[k]--;
        else if (!BranchTakenE && lu) rem[k] = ll[k] - 1;
      end
    end
  endtask

  task automatic cyc(input logic rs, input logic mr, input logic [4:0] rd, input logic [4:0] r1,
                     input logic [4:0] r2, input logic br, input logic mb);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rs; MemReadE = mr; RdE = rd; Rs1D = r1; Rs2D = r2; BranchTakenE = br; MemBusyM = mb;
    e = predict(0); qa.push_back(e); advance(0, e.ctl[5]);
    e = predict(1); qb.push_back(e); advance(1, e.ctl[5]);
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", n, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      chk("a_ctl", {26'd0, sf_a, sd_a, se_a, sm_a, fd_a, fe_a}, {26'd0, e.ctl});
      if (e.regs) begin
        chk("a_state", {30'd0, hs_a}, {30'd0, e.hs});
        chk("a_timeout", {31'd0, to_a}, {31'd0, e.to});
        chk("a_stall_cycles", sc_a, e.sc);
      end
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      chk("b_ctl", {26'd0, sf_b, sd_b, se_b, sm_b, fd_b, fe_b}, {26'd0, e.ctl});
      if (e.regs) begin
        chk("b_state", {30'd0, hs_b}, {30'd0, e.hs});
        chk("b_timeout", {31'd0, to_b}, {31'd0, e.to});
        chk("b_stall_cycles", {28'd0, sc_b}, e.sc);
      end
    end
  end

  initial begin
    repeat (2) cyc(0, 1, 5, 5, 5, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 5, 5, 0, 0, 0);
    repeat (3) cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 7, 1, 7, 0, 0);
    cyc(1, 1, 7, 1, 7, 0, 0);
    repeat (2) cyc(1, 1, 7, 1, 7, 0, 1);
    repeat (3) cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 9, 9, 9, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    repeat (4) cyc(1, 0, 0, 0, 0, 0, 1);
    repeat (2) cyc(1, 0, 0, 0, 0, 0, 0);
    repeat (20) cyc(1, 0, 0, 0, 0, 0, 1);
    cyc(1, 1, 3, 3, 0, 0, 0);
    cyc(0, 1, 3, 3, 0, 0, 0);
    repeat (2) cyc(1, 0, 0, 0, 0, 0, 0);
    repeat (3000) begin
      cyc($urandom_range(99) != 0, $urandom_range(1), 5'($urandom_range(3)),
          5'($urandom_range(3)), 5'($urandom_range(3)), $urandom_range(99) < 15,
          $urandom_range(99) < 15);
    end
    repeat (2) @(posedge clk);
    chk("queue_a_drained", qa.size(), 0);
    chk("queue_b_drained", qb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
Sequences stall and flush control for the 5-stage RV32 pipeline.
- Detects load-use hazards between the instruction in EX and the one in decode.
- Inserts a configurable number of bubbles via the decode-stage flush input (FlushE) and the IF/ID stalls.
- Kills wrong-path instructions on a taken branch/jump.
- Freezes the whole front end while data memory is busy, with a watchdog timeout and a saturating stall-cycle counter.

Parameters:
LOAD_LATENCY, 1, bubbles inserted per load-use hazard (1..7)
MAX_WAIT, 255, MemBusyM cycles before mem_timeout sets (1..255)
CNT_W, 32, width of stall_cycles counter

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-low reset
Rs1D  in  5  rs1 field of instruction in decode
Rs2D  in  5  rs2 field of instruction in decode
RdE  in  5  rd of instruction in EX
MemReadE  in  1  instruction in EX is a load
BranchTakenE  in  1  branch/jump resolved taken in EX
MemBusyM  in  1  data memory not ready; MEM stage must hold
StallF  out  1  hold PC
StallD  out  1  hold IF/ID register
StallE  out  1  hold ID/EX register
StallM  out  1  hold EX/MEM register
FlushD  out  1  zero IF/ID register (insert NOP)
FlushE  out  1  mask decode control signals (bubble into EX)
hazard_state  out  2  00 RUN, 01 LOAD_STALL, 10 MEM_WAIT
mem_timeout  out  1  sticky; MemBusyM held MAX_WAIT consecutive cycles
stall_cycles  out  CNT_W  count of cycles with StallF=1, saturating

Behaviour:
- State, bub_cnt (3b), wait_cnt (8b), mem_timeout and stall_cycles are registered. Stall/flush outputs are combinational (Mealy) from state and inputs.
- While reset==0: all stall/flush outputs 0. At the next edge: state=RUN, bub_cnt=0, wait_cnt=0, mem_timeout=0, stall_cycles=0. Reset mid-stall abandons the stall immediately.
- Load-use hit (lu) = MemReadE && RdE!=0 && (RdE==Rs1D || RdE==Rs2D). x0 never hazards.
- Priority in every state: MemBusyM > BranchTakenE > lu.
- RUN:
  - MemBusyM=1: StallF=StallD=StallE=StallM=1, no flush. Next MEM_WAIT, wait_cnt<=1.
  - Else BranchTakenE=1: FlushD=FlushE=1, no stall. Stay RUN. A coincident lu is dropped because the decode instruction is killed.
  - Else lu: StallF=StallD=1, FlushE=1. If LOAD_LATENCY==1, stay RUN; else next LOAD_STALL with bub_cnt<=LOAD_LATENCY-1.
  - Else all 0.
- LOAD_STALL:
  - MemBusyM=1: StallF..StallM=1, FlushE=0, bub_cnt held, wait_cnt increments, stay LOAD_STALL.
  - Otherwise: StallF=StallD=1, FlushE=1, bub_cnt decrements; when bub_cnt==1, next RUN.
  - BranchTakenE is ignored (EX holds a bubble).
- MEM_WAIT:
  - MemBusyM=1: StallF..StallM=1, wait_cnt increments, saturating at 255.
  - MemBusyM=0: outputs and next state evaluated exactly as RUN in the same cycle, wait_cnt<=0.
- wait_cnt clears whenever MemBusyM=0.
- mem_timeout sets on the edge where wait_cnt==MAX_WAIT with MemBusyM=1, and stays set until reset. The stall continues after timeout; no forced release.
- stall_cycles increments on every edge with StallF=1 and reset==1. It holds at 2^CNT_W-1.
- Total load-use latency: exactly LOAD_LATENCY cycles with FlushE=1, excluding MemBusyM freeze cycles. The decode instruction then proceeds.

Test Plan:
1. Reset=0 for 2 cycles with lu inputs active → all stall/flush=0. After release: hazard_state=00, stall_cycles=0, mem_timeout=0.
2. LOAD_LATENCY=1, MemReadE=1, RdE=5, Rs1D=5 for one cycle → StallF=StallD=FlushE=1 that cycle only, stall_cycles=1. With RdE=0 and Rs1D=0 → no stall.
3. LOAD_LATENCY=3, lu on Rs2D=7=RdE → FlushE=1 for 3 consecutive cycles, hazard_state 00→01→01→00. MemBusyM=1 for 2 cycles in the middle → FlushE=0 and StallM=1 on those cycles; total bubble cycles still 3.
4. BranchTakenE=1 together with lu → FlushD=FlushE=1, StallF=0, state stays RUN.
5. MemBusyM=1 for 4 cycles → StallF..StallM=1 for exactly 4 cycles, hazard_state=10 from the 2nd cycle, release same cycle MemBusyM falls. MAX_WAIT=3 → mem_timeout=1 after 3rd busy edge, sticky until reset.
6. CNT_W=4, hold a stall for 20 cycles → stall_cycles saturates at 15. Reset asserted mid-LOAD_STALL → outputs 0 immediately, state RUN after edge.
